// File: rtl/vga_pixel_pipe.sv
// vga_pixel_pipe
//   VGA timing generator plus pixel output stage. Issues (x,y) requests to a
//   pixel source, delays all timing/control by the source read latency, and
//   registers syncs, video enable and expanded per-channel colour.
// Ports
//   i_clk, i_rstn          pixel clock, async active-low reset
//   i_mode                 0 pass-through, 1 colour bars, 2 grid, 3 black
//   i_pixel_data           {R,G,B} from source, valid RD_LAT clocks after req
//   o_req_x/o_req_y        requested pixel (raw counters, zero latency)
//   o_req_valid            request lies in the active area
//   o_frame_start          1-clk pulse with output pixel (0,0)
//   o_hsync/o_vsync        latency-aligned syncs, active level SYNC_POL
//   o_video                latency-aligned active-area enable
//   o_red/o_green/o_blue   CW-bit colour, 0 outside active area
module vga_pixel_pipe #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int RD_LAT   = 2,
  parameter int IN_R     = 4,
  parameter int IN_G     = 3,
  parameter int IN_B     = 4,
  parameter int CW       = 4,
  localparam int PIX_W   = IN_R + IN_G + IN_B
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [1:0]       i_mode,
  input  logic [PIX_W-1:0] i_pixel_data,
  output logic [10:0]      o_req_x,
  output logic [10:0]      o_req_y,
  output logic             o_req_valid,
  output logic             o_frame_start,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_video,
  output logic [CW-1:0]    o_red,
  output logic [CW-1:0]    o_green,
  output logic [CW-1:0]    o_blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  if (H_TOTAL > 2047 || V_TOTAL > 2047 || RD_LAT > 4 || RD_LAT < 0) begin : g_bad_cfg
    $error("vga_pixel_pipe: H_TOTAL/V_TOTAL must be <= 2047 and RD_LAT in 0..4");
  end

  localparam logic [10:0] HA    = 11'(H_ACTIVE);
  localparam logic [10:0] VA    = 11'(V_ACTIVE);
  localparam logic [10:0] HS0   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS1   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS0   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS1   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] HLAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] VLAST = 11'(V_TOTAL - 1);

  // Everything the output stage needs about one request, carried down the
  // latency line together so it stays aligned with the returned pixel.
  typedef struct packed {
    logic        vld;
    logic        hs;    // raw sync, 1 = active
    logic        vs;
    logic        fs;
    logic [1:0]  mode;
    logic [10:0] x;
    logic [10:0] y;
  } stage_t;

  logic [10:0] r_h_cnt, r_v_cnt;
  logic [1:0]  r_mode;
  logic        w_first;
  stage_t      w_cur, w_tap;

  assign w_first = (r_h_cnt == '0) && (r_v_cnt == '0);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_mode  <= '0;
    end else begin
      if (r_h_cnt == HLAST) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == VLAST) ? '0 : r_v_cnt + 11'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 11'd1;
      end
      if (w_first) r_mode <= i_mode;
    end
  end

  // Mode rides with the request; on the first pixel the freshly sampled
  // value is used so the whole new frame switches at once.
  always_comb begin
    w_cur.vld  = (r_h_cnt < HA) && (r_v_cnt < VA);
    w_cur.hs   = (r_h_cnt >= HS0) && (r_h_cnt < HS1);
    w_cur.vs   = (r_v_cnt >= VS0) && (r_v_cnt < VS1);
    w_cur.fs   = w_first;
    w_cur.mode = w_first ? i_mode : r_mode;
    w_cur.x    = r_h_cnt;
    w_cur.y    = r_v_cnt;
  end

  assign o_req_x     = r_h_cnt;
  assign o_req_y     = r_v_cnt;
  assign o_req_valid = w_cur.vld;

  if (RD_LAT == 0) begin : g_nodly
    assign w_tap = w_cur;
  end else begin : g_dly
    stage_t r_dly [RD_LAT];
    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        r_dly <= '{default: '0};
      end else begin
        r_dly[0] <= w_cur;
        for (int i = 1; i < RD_LAT; i++) r_dly[i] <= r_dly[i-1];
      end
    end
    assign w_tap = r_dly[RD_LAT-1];
  end

  // Channel expansion: output bit CW-1-i takes input bit N-1-(i mod N), which
  // truncates wide channels and MSB-replicates narrow ones.
  logic [IN_R-1:0] w_pix_r;
  logic [IN_G-1:0] w_pix_g;
  logic [IN_B-1:0] w_pix_b;
  logic [CW-1:0]   w_exp_r, w_exp_g, w_exp_b;

  assign w_pix_r = i_pixel_data[PIX_W-1 -: IN_R];
  assign w_pix_g = i_pixel_data[IN_B +: IN_G];
  assign w_pix_b = i_pixel_data[IN_B-1:0];

  for (genvar i = 0; i < CW; i++) begin : g_exp
    assign w_exp_r[CW-1-i] = w_pix_r[IN_R-1-(i % IN_R)];
    assign w_exp_g[CW-1-i] = w_pix_g[IN_G-1-(i % IN_G)];
    assign w_exp_b[CW-1-i] = w_pix_b[IN_B-1-(i % IN_B)];
  end

  // Bar index by threshold compare; anything past bar 7's start stays in 7,
  // so the last bar absorbs the remainder.
  logic [2:0]    w_bar;
  logic          w_grid;
  logic [CW-1:0] w_r, w_g, w_b;

  always_comb begin
    w_bar = '0;
    for (int b = 1; b < 8; b++)
      if (w_tap.x >= 11'(b * BAR_W)) w_bar = 3'(b);
  end

  assign w_grid = (w_tap.x[4:0] == '0) || (w_tap.y[4:0] == '0) ||
                  (w_tap.x == HA - 11'd1) || (w_tap.y == VA - 11'd1);

  // Bar order white..black: R off for bars 2,3,6,7, G off for 4..7, B off for odd.
  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    if (w_tap.vld) begin
      unique case (w_tap.mode)
        2'd0: begin w_r = w_exp_r; w_g = w_exp_g; w_b = w_exp_b; end
        2'd1: begin
          w_r = {CW{~w_bar[1]}};
          w_g = {CW{~w_bar[2]}};
          w_b = {CW{~w_bar[0]}};
        end
        2'd2: begin w_r = {CW{w_grid}}; w_g = {CW{w_grid}}; w_b = {CW{w_grid}}; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_video       <= 1'b0;
      o_frame_start <= 1'b0;
      o_hsync       <= ~SYNC_POL;
      o_vsync       <= ~SYNC_POL;
      o_red         <= '0;
      o_green       <= '0;
      o_blue        <= '0;
    end else begin
      o_video       <= w_tap.vld;
      o_frame_start <= w_tap.fs;
      o_hsync       <= w_tap.hs ? SYNC_POL : ~SYNC_POL;
      o_vsync       <= w_tap.vs ? SYNC_POL : ~SYNC_POL;
      o_red         <= w_r;
      o_green       <= w_g;
      o_blue        <= w_b;
    end
  end

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Bench for vga_pixel_pipe: a default-geometry instance (RD_LAT=2, active-low
// syncs) and a tiny-geometry instance (24x12 total, RD_LAT=0, active-high).
module tb_vga_pixel_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [1:0]  mode, mode_s;
  logic        force_pix;

  // default instance signals
  logic [10:0] req_x, req_y, src_d1, src_d2, pix;
  logic        req_v, fs, hs, vs, vid;
  logic [3:0]  r, g, b;

  // small instance signals
  logic [10:0] req_x_s, req_y_s, pix_s;
  logic        req_v_s, fs_s, hs_s, vs_s, vid_s;
  logic [3:0]  r_s, g_s, b_s;

  // source model: {x[3:0], y[2:0], x[7:4]} returned two clocks after request
  always @(posedge clk) begin
    src_d1 <= {req_x[3:0], req_y[2:0], req_x[7:4]};
    src_d2 <= src_d1;
  end
  assign pix   = force_pix ? {4'h5, 3'b101, 4'hB} : src_d2;
  assign pix_s = {req_x_s[3:0], req_y_s[2:0], req_x_s[7:4]};

  vga_pixel_pipe dut (
    .i_clk(clk), .i_rstn(rstn), .i_mode(mode), .i_pixel_data(pix),
    .o_req_x(req_x), .o_req_y(req_y), .o_req_valid(req_v),
    .o_frame_start(fs), .o_hsync(hs), .o_vsync(vs), .o_video(vid),
    .o_red(r), .o_green(g), .o_blue(b));

  vga_pixel_pipe #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .RD_LAT(0)
  ) dut_s (
    .i_clk(clk), .i_rstn(rstn), .i_mode(mode_s), .i_pixel_data(pix_s),
    .o_req_x(req_x_s), .o_req_y(req_y_s), .o_req_valid(req_v_s),
    .o_frame_start(fs_s), .o_hsync(hs_s), .o_vsync(vs_s), .o_video(vid_s),
    .o_red(r_s), .o_green(g_s), .o_blue(b_s));

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  // request history of the default instance; hx[3] is what the output shows now
  logic [10:0] hx [4];
  logic [10:0] hy [4];
  logic        hv [4];

  task automatic tick();
    @(negedge clk);
    for (int i = 3; i > 0; i--) begin
      hx[i] = hx[i-1]; hy[i] = hy[i-1]; hv[i] = hv[i-1];
    end
    hx[0] = req_x; hy[0] = req_y; hv[0] = 1'b1;
    cyc++;
  endtask

  task automatic release_rst();
    rstn = 1'b1;
    hx[0] = req_x; hy[0] = req_y; hv[0] = 1'b1;
    for (int i = 1; i < 4; i++) hv[i] = 1'b0;
    cyc = 0;
  endtask

  task automatic reset_with(input logic [1:0] m);
    @(negedge clk);
    rstn = 1'b0;
    mode = m;
    @(negedge clk);
    release_rst();
  endtask

  task automatic to_out(input int x, input int y);
    int n = 0;
    while (!(hv[3] && hx[3] == 11'(x) && hy[3] == 11'(y)) && n < 5000) begin
      tick();
      n++;
    end
    chk("wait_out_budget", 32'(n < 5000), 1);
  endtask

  task automatic to_req(input int x, input int y);
    int n = 0;
    while (!(hx[0] == 11'(x) && hy[0] == 11'(y)) && n < 5000) begin
      tick();
      n++;
    end
    chk("wait_req_budget", 32'(n < 5000), 1);
  endtask

  // pass-through expectation: R=x[3:0], G=y[2:0] with MSB repeated, B=x[7:4]
  task automatic pt_check();
    logic [10:0] x, y;
    logic        v;
    if (!hv[3]) return;
    x = hx[3]; y = hy[3];
    v = (x < 640) && (y < 480);
    chk("pt_rgb", {r, g, b}, v ? {x[3:0], y[2:0], y[2], x[7:4]} : 12'h000);
    chk("pt_video", vid, v);
    chk("pt_hsync", hs, !(x >= 656 && x < 752));
    chk("pt_vsync", vs, !(y >= 490 && y < 492));
    chk("pt_fstart", fs, (x == 0) && (y == 0));
  endtask

  task automatic run_pt(input int n);
    int t_vid = -1, t_hsf = -1, nfall = 0;
    logic p_hs = 1'b1, p_vid = 1'b0;
    for (int k = 0; k < n; k++) begin
      tick();
      pt_check();
      if (vid && !p_vid) t_vid = cyc;
      if (!hs && p_hs) begin
        if (t_hsf >= 0) chk("hs_period", cyc - t_hsf, 800);
        chk("hs_fall_after_video", cyc - t_vid, 656);
        t_hsf = cyc;
        nfall++;
      end
      if (hs && !p_hs) chk("hs_low_width", cyc - t_hsf, 96);
      p_hs = hs; p_vid = vid;
    end
    chk("hs_fall_count", nfall, 2);
  endtask

  int          bx [12] = '{0, 79, 80, 159, 160, 240, 320, 400, 480, 559, 560, 639};
  logic [11:0] bc [12] = '{12'hFFF, 12'hFFF, 12'hFF0, 12'hFF0, 12'h0FF, 12'h0F0,
                           12'hF0F, 12'hF00, 12'h00F, 12'h00F, 12'h000, 12'h000};
  logic [11:0] bar8 [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                            12'hF0F, 12'hF00, 12'h00F, 12'h000};
  int          gx [6] = '{5, 1, 32, 33, 638, 639};
  int          gy [6] = '{0, 1, 1, 1, 1, 1};
  logic [11:0] gc [6] = '{12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'hFFF};

  initial begin
    rstn = 1'b0; mode = 2'd0; mode_s = 2'd0; force_pix = 1'b0;
    for (int i = 0; i < 4; i++) begin hx[i] = '0; hy[i] = '0; hv[i] = 1'b0; end

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_syncs", {hs, vs}, 2'b11);
    chk("rst_video", vid, 0);
    chk("rst_rgb", {r, g, b}, 0);
    chk("rst_fstart", fs, 0);
    chk("rst_s_syncs", {hs_s, vs_s}, 2'b00);
    release_rst();
    chk("rel_req", {req_v, req_x, req_y}, {1'b1, 22'd0});

    // pass-through across two-plus lines with hsync timing
    run_pt(1700);

    // asynchronous reset in the middle of a line
    to_req(300, 2);
    chk("pre_rst_video", vid, 1);
    #1 rstn = 1'b0;
    #1;
    chk("mid_rst_syncs", {hs, vs}, 2'b11);
    chk("mid_rst_video", vid, 0);
    chk("mid_rst_rgb", {r, g, b}, 0);
    chk("mid_rst_req", {req_v, req_x, req_y}, {1'b1, 22'd0});
    @(negedge clk);
    release_rst();

    // fixed pixel {5, 101, B}: G expands to 1011
    force_pix = 1'b1;
    to_out(100, 0);
    chk("pix_fixed_rgb", {r, g, b}, 12'h5BB);
    chk("pix_fixed_video", vid, 1);
    to_out(700, 0);
    chk("pix_blank_rgb", {r, g, b}, 12'h000);
    chk("pix_blank_video", vid, 0);
    force_pix = 1'b0;

    // colour bars; the mode input drops mid-frame and must be ignored
    reset_with(2'd1);
    to_out(0, 0);
    chk("bars_fstart", fs, 1);
    mode = 2'd0;
    for (int i = 0; i < 12; i++) begin
      to_out(bx[i], 0);
      chk("bars_rgb", {r, g, b}, bc[i]);
      chk("bars_video", vid, 1);
    end
    to_out(640, 0);
    chk("bars_blank_rgb", {r, g, b}, 12'h000);

    // grid
    reset_with(2'd2);
    for (int i = 0; i < 6; i++) begin
      to_out(gx[i], gy[i]);
      chk("grid_rgb", {r, g, b}, gc[i]);
    end

    // black
    reset_with(2'd3);
    to_out(5, 0);
    chk("black_rgb", {r, g, b}, 12'h000);
    chk("black_video", vid, 1);

    // small instance: active-high syncs, 1-clk latency, 3 whole frames,
    // mode switched to bars mid frame 0 -> bars from frame 1 only
    @(negedge clk);
    rstn = 1'b0;
    mode_s = 2'd0;
    #1;
    chk("s_rst_syncs", {hs_s, vs_s}, 2'b00);
    chk("s_rst_video", vid_s, 0);
    @(negedge clk);
    rstn = 1'b1;
    begin
      logic [10:0] px, py;
      logic [11:0] e;
      logic        v, p_vs;
      int nfs, nvs, nhs, tvr;
      px = req_x_s; py = req_y_s;
      nfs = 0; nvs = 0; nhs = 0; tvr = -1; p_vs = 1'b0;
      for (int t = 1; t <= 864; t++) begin
        @(negedge clk);
        v = (px < 16) && (py < 8);
        if (!v)                e = 12'h000;
        else if (t - 1 >= 288) e = bar8[px[3:1]];
        else                   e = {px[3:0], py[2:0], py[2], px[7:4]};
        chk("s_rgb", {r_s, g_s, b_s}, e);
        chk("s_video", vid_s, v);
        chk("s_hsync", hs_s, (px >= 18) && (px < 21));
        chk("s_vsync", vs_s, (py >= 9) && (py < 11));
        chk("s_fstart", fs_s, (px == 0) && (py == 0));
        chk("s_req_valid", req_v_s, (req_x_s < 16) && (req_y_s < 8));
        if (fs_s) nfs++;
        if (vs_s) nvs++;
        if (hs_s) nhs++;
        if (vs_s && !p_vs) begin
          if (tvr >= 0) chk("s_vs_period", t - tvr, 288);
          tvr = t;
        end
        p_vs = vs_s;
        if (t == 100) mode_s = 2'd1;
        px = req_x_s; py = req_y_s;
      end
      chk("s_fstart_count", nfs, 3);
      chk("s_vs_high", nvs, 144);
      chk("s_hs_high", nhs, 108);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
